// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: walks the keypad column drive, debounces the external
// encoder's key-detect line, and publishes one {row,col} code per press.
// Optional feature: define KEY_REPEAT_EN to add auto-repeat pulses while a key
// stays held (REPEAT_DLY cycles to the first repeat, then every REPEAT_PER).
module keypad_scan_fsm #(
    parameter int SCAN_DIV   = 10000,
    parameter int DB_CYCLES  = 100000,
    parameter int REPEAT_DLY = 5000000,
    parameter int REPEAT_PER = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_det_i,
    input  logic [1:0] row_i,
    output logic [1:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       busy_o
);

    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          det_m;
    logic          det_s;
    logic [1:0]    row_m;
    logic [1:0]    row_s;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nx;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nx;
    logic [1:0]    col_nx;
    logic [3:0]    code_nx;
    logic          valid_nx;

`ifdef KEY_REPEAT_EN
    localparam int RTOP = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RTOP + 1);
    localparam logic [RW-1:0] REP_DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] REP_PER_LAST = RW'(REPEAT_PER - 1);
    localparam logic [RW-1:0] REP_MAX      = RW'(RTOP);

    logic [RW-1:0] rep;
    logic [RW-1:0] rep_nx;
    logic          rep_first;
    logic          rep_first_nx;
`endif

    // Two-flop synchronizer for the asynchronous encoder inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            det_m <= 1'b0;
            det_s <= 1'b0;
            row_m <= 2'd0;
            row_s <= 2'd0;
        end else begin
            det_m <= key_det_i;
            det_s <= det_m;
            row_m <= row_i;
            row_s <= row_m;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= SCAN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, counter and output decisions.
    always_comb begin
        state_nx = state;
        pre_nx   = pre;
        cnt_nx   = cnt;
        col_nx   = col_o;
        code_nx  = key_code_o;
        valid_nx = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_nx       = rep;
        rep_first_nx = rep_first;
`endif
        case (state)
            SCAN: begin
                if (det_s) begin
                    // Freeze the column: the detected key belongs to it.
                    state_nx = DEBOUNCE;
                    pre_nx   = '0;
                    cnt_nx   = '0;
                end else if (pre == PRE_LAST) begin
                    pre_nx = '0;
                    col_nx = col_o + 2'd1;
                end else begin
                    pre_nx = pre + PW'(1);
                end
            end
            DEBOUNCE: begin
                if (!det_s) begin
                    state_nx = SCAN;
                end else if (cnt == DB_LAST) begin
                    state_nx = HOLD;
                    code_nx  = {row_s, col_o};
                    valid_nx = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_nx       = '0;
                    rep_first_nx = 1'b1;
`endif
                end else begin
                    cnt_nx = cnt + DW'(1);
                end
            end
            HOLD: begin
                if (!det_s) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if ((rep_first && (rep == REP_DLY_LAST)) ||
                        (!rep_first && (rep == REP_PER_LAST))) begin
                        valid_nx     = 1'b1;
                        rep_nx       = '0;
                        rep_first_nx = 1'b0;
                    end else if (rep != REP_MAX) begin
                        rep_nx = rep + RW'(1);
                    end else begin
                        rep_nx = rep;
                    end
`else
                    state_nx = HOLD;
`endif
                end
            end
            RELEASE: begin
                if (det_s) begin
                    // Bounce on release: back to holding, no new event.
                    state_nx = HOLD;
`ifdef KEY_REPEAT_EN
                    rep_nx       = '0;
                    rep_first_nx = 1'b1;
`endif
                end else if (cnt == DB_LAST) begin
                    state_nx = SCAN;
                end else begin
                    cnt_nx = cnt + DW'(1);
                end
            end
            default: begin
                state_nx = SCAN;
                pre_nx   = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    // Counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre         <= '0;
            cnt         <= '0;
            col_o       <= 2'd0;
            key_code_o  <= 4'd0;
            key_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            pre         <= pre_nx;
            cnt         <= cnt_nx;
            col_o       <= col_nx;
            key_code_o  <= code_nx;
            key_valid_o <= valid_nx;
            busy_o      <= (state_nx != SCAN);
        end
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat timing registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rep       <= '0;
            rep_first <= 1'b1;
        end else begin
            rep       <= rep_nx;
            rep_first <= rep_first_nx;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Bench for keypad_scan_fsm: a behavioural reference model (phase + elapsed
// time arithmetic) checked every cycle, plus directed literal checks.
module tb_keypad_scan_fsm;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int RD = 20;
    localparam int RP = 6;
`ifdef KEY_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       key_det_i = 1'b0;
    logic [1:0] row_i = 2'd0;
    logic [1:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       busy_o;

    int tests = 0;
    int fails = 0;
    int ecount = 0;
    int pulses = 0;
    int base = 0;

    keypad_scan_fsm #(
        .SCAN_DIV(SD), .DB_CYCLES(DB), .REPEAT_DLY(RD), .REPEAT_PER(RP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .key_det_i(key_det_i), .row_i(row_i),
        .col_o(col_o), .key_code_o(key_code_o), .key_valid_o(key_valid_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Edge numbering: first posedge after reset release is edge 1.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) ecount = 0;
        else ecount = ecount + 1;
    end

    // Reference model: phases of a key press with elapsed-time bookkeeping.
    localparam int P_IDLE = 0, P_PRESS = 1, P_DOWN = 2, P_UP = 3;
    bit         pd[2];
    logic [1:0] pr[2];
    int phase, scan_time, col_base, run, age;
    int e_col, e_code;
    bit e_valid, e_busy;

    always @(posedge clk or posedge rst_i) begin
        bit         sd;
        logic [1:0] sr;
        if (rst_i) begin
            pd[0] = 0; pd[1] = 0; pr[0] = 2'd0; pr[1] = 2'd0;
            phase = P_IDLE; scan_time = 0; col_base = 0; run = 0; age = 0;
            e_col = 0; e_code = 0; e_valid = 0; e_busy = 0;
        end else begin
            sd = pd[1];
            sr = pr[1];
            pd[1] = pd[0]; pd[0] = key_det_i;
            pr[1] = pr[0]; pr[0] = row_i;
            e_valid = 0;
            case (phase)
                P_IDLE: begin
                    if (sd) begin
                        phase = P_PRESS; col_base = e_col; scan_time = 0; run = 0;
                    end else begin
                        scan_time = scan_time + 1;
                        e_col = (col_base + scan_time / SD) % 4;
                    end
                end
                P_PRESS: begin
                    if (!sd) phase = P_IDLE;
                    else begin
                        run = run + 1;
                        if (run > DB) begin
                            phase = P_DOWN; e_code = sr * 4 + e_col; e_valid = 1; age = 0;
                        end
                    end
                end
                P_DOWN: begin
                    if (!sd) begin
                        phase = P_UP; run = 0;
                    end else if (REP == 1) begin
                        age = age + 1;
                        if (age == RD || (age > RD && (age - RD) % RP == 0)) e_valid = 1;
                    end
                end
                default: begin
                    if (sd) begin
                        phase = P_DOWN; age = 0;
                    end else begin
                        run = run + 1;
                        if (run > DB) phase = P_IDLE;
                    end
                end
            endcase
            e_busy = (phase != P_IDLE);
        end
    end

    // Every-cycle comparison against the model, plus pulse counting.
    always @(posedge clk) begin
        #3;
        tests = tests + 1;
        if (col_o !== e_col[1:0] || key_code_o !== e_code[3:0] ||
            key_valid_o !== e_valid || busy_o !== e_busy) begin
            fails = fails + 1;
            $display("FAIL model t=%0t col %0d/%0d code %h/%h valid %b/%b busy %b/%b (got/exp)",
                     $time, col_o, e_col[1:0], key_code_o, e_code[3:0],
                     key_valid_o, e_valid, busy_o, e_busy);
        end
        if (key_valid_o === 1'b1) pulses = pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto_edge(input int n);
        int guard = 0;
        while (ecount != n && guard < 1000) begin
            @(posedge clk);
            #3;
            guard++;
        end
        if (ecount != n) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL goto_edge: at %0d wanted %0d", ecount, n);
        end
    endtask

    task automatic do_reset(input bit keep_key);
        @(negedge clk);
        if (!keep_key) begin
            key_det_i = 1'b0;
            row_i = 2'd0;
        end
        rst_i = 1'b1;
        #1;
        check("rst col", col_o, 0);
        check("rst code", key_code_o, 0);
        check("rst valid", key_valid_o, 0);
        check("rst busy", busy_o, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        base = pulses;
    endtask

    // Key sampled high first at edge k (k >= 2).
    task automatic press(input int k, input logic [1:0] row);
        goto_edge(k - 1);
        @(negedge clk);
        key_det_i = 1'b1;
        row_i = row;
    endtask

    int         tk[4] = '{4, 13, 9, 2};
    logic [1:0] tr[4] = '{2'd2, 2'd1, 2'd3, 2'd1};
    int         tc[4] = '{9, 7, 14, 4};
    int         tv[4] = '{15, 24, 20, 13};

    initial begin
        // Idle scanning after reset.
        do_reset(1'b0);
        for (int n = 1; n <= 40; n++) begin
            goto_edge(n);
            check("idle col", col_o, (n / 4) % 4);
            check("idle valid", key_valid_o, 0);
        end

        // Accepted presses: latency and {row,col} code.
        for (int i = 0; i < 4; i++) begin
            do_reset(1'b0);
            press(tk[i], tr[i]);
            goto_edge(tv[i] - 1);
            check("pre-accept valid", key_valid_o, 0);
            check("debounce busy", busy_o, 1);
            goto_edge(tv[i]);
            check("accept valid", key_valid_o, 1);
            check("accept code", key_code_o, tc[i]);
            goto_edge(tv[i] + 1);
            check("valid one-shot", key_valid_o, 0);
            check("code held", key_code_o, tc[i]);
            @(negedge clk);
            key_det_i = 1'b0;
            goto_edge(tv[i] + 20);
        end

        // Five-cycle glitch: rejected, scanning resumes from frozen column.
        do_reset(1'b0);
        press(4, 2'd2);
        goto_edge(8);
        @(negedge clk);
        key_det_i = 1'b0;
        goto_edge(10);
        check("glitch busy", busy_o, 1);
        goto_edge(11);
        check("glitch back to scan", busy_o, 0);
        check("glitch frozen col", col_o, 1);
        goto_edge(14);
        check("glitch col hold", col_o, 1);
        goto_edge(15);
        check("glitch col resume", col_o, 2);
        goto_edge(20);
        check("glitch pulses", pulses - base, 0);

        // Release dropout then full release.
        do_reset(1'b0);
        press(4, 2'd2);
        goto_edge(15);
        check("dropout accept", key_valid_o, 1);
        goto_edge(19);
        @(negedge clk);
        key_det_i = 1'b0;
        goto_edge(22);
        @(negedge clk);
        key_det_i = 1'b1;
        goto_edge(24);
        check("dropout busy", busy_o, 1);
        goto_edge(29);
        @(negedge clk);
        key_det_i = 1'b0;
        goto_edge(40);
        check("release busy", busy_o, 1);
        goto_edge(41);
        check("release idle", busy_o, 0);
        check("release code", key_code_o, 9);
        check("dropout pulses", pulses - base, 1);

        // Reset four cycles into debounce with the key still held.
        do_reset(1'b0);
        press(4, 2'd2);
        goto_edge(9);
        check("mid-debounce busy", busy_o, 1);
        do_reset(1'b1);
        goto_edge(11);
        check("re-debounce valid early", key_valid_o, 0);
        check("re-debounce pulses", pulses - base, 0);
        goto_edge(12);
        check("re-debounce valid", key_valid_o, 1);
        check("re-debounce code", key_code_o, 8);

        // Long hold: repeat pulses only when the feature is built in.
        do_reset(1'b0);
        press(4, 2'd2);
        goto_edge(34);
        check("hold valid 34", key_valid_o, 0);
        goto_edge(35);
        check("hold valid 35", key_valid_o, REP);
        goto_edge(55);
        check("hold pulses", pulses - base, (REP == 1) ? 5 : 1);
        check("hold code", key_code_o, 9);
        @(negedge clk);
        key_det_i = 1'b0;
        goto_edge(70);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
